soc_system_sw_poller: RTL and testbench

Avalon-MM master that sits at the other end of the switch PIO slave, a read-only Avalon-MM slave with registered readdata and read latency 1. It periodically reads PIO offset 0, debounces each sample in the time domain and presents a clean switch vector to fabric logic. It also emits a one-cycle change strobe. It sits between the switch PIO slave and the balance-control fabric logic, so that logic never sees raw switch bounce.

---
 rtl/soc_system_pio_pkg.sv | 20 ++
 rtl/soc_system_sw_debounce.sv | 92 +++++++++
 rtl/soc_system_sw_poller.sv | 142 ++++++++++++++
 tb/tb_soc_system_sw_poller.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_system_pio_pkg.sv
// ---------------------------------------------------------------------------
// soc_system_pio_pkg
// Shared definitions for the switch PIO poller:
//   - poll_state_e : Avalon read FSM states
//   - PIO_DATA_OFFSET : word offset of the PIO data register
//   - DEFAULT_READ_LATENCY : read latency of the PIO slave
// ---------------------------------------------------------------------------
package soc_system_pio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } poll_state_e;

    localparam logic [1:0] PIO_DATA_OFFSET      = 2'd0;
    localparam int         DEFAULT_READ_LATENCY = 1;

endpackage

// File: rtl/soc_system_sw_debounce.sv
// ---------------------------------------------------------------------------
// soc_system_sw_debounce
// Time-domain debouncer driven by discrete samples. A value is accepted once
// DEBOUNCE_N consecutive identical samples have been seen.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   sample         sampled switch vector
//   sample_valid   one-cycle qualifier for sample
//   stable         debounced switch vector (registered)
//   valid          set by the first accepted value (registered)
//   changed        one-cycle pulse on each later accepted change (registered)
// ---------------------------------------------------------------------------
module soc_system_sw_debounce #(
    parameter int DATA_W     = 4,
    parameter int DEBOUNCE_N = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] sample,
    input  logic              sample_valid,
    output logic [DATA_W-1:0] stable,
    output logic              valid,
    output logic              changed
);

    localparam int             CNT_W   = $clog2(DEBOUNCE_N + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_N);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] cand_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] stable_r;
    logic              valid_r;
    logic              changed_r;

    logic [DATA_W-1:0] next_cand_s;
    logic [CNT_W-1:0]  next_cnt_s;
    logic              accept_s;

    // Next candidate and saturating match count for the incoming sample
    always_comb begin
        next_cand_s = cand_r;
        next_cnt_s  = cnt_r;
        if (sample != cand_r) begin
            next_cand_s = sample;
            next_cnt_s  = CNT_ONE;
        end else if (cnt_r < CNT_MAX) begin
            next_cnt_s  = cnt_r + CNT_ONE;
        end else begin
            next_cnt_s  = CNT_MAX;
        end
    end

    // Accept when the run is long enough and it brings something new
    // (a different value, or the very first value after reset)
    always_comb begin
        accept_s = 1'b0;
        if (sample_valid && (next_cnt_s == CNT_MAX) &&
            ((next_cand_s != stable_r) || !valid_r)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Candidate/count tracking and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand_r    <= '0;
            cnt_r     <= '0;
            stable_r  <= '0;
            valid_r   <= 1'b0;
            changed_r <= 1'b0;
        end else begin
            if (sample_valid) begin
                cand_r <= next_cand_s;
                cnt_r  <= next_cnt_s;
            end
            if (accept_s) begin
                stable_r <= next_cand_s;
                valid_r  <= 1'b1;
            end
            // The first acceptance only raises valid; it is not a change
            changed_r <= accept_s & valid_r;
        end
    end

    assign stable  = stable_r;
    assign valid   = valid_r;
    assign changed = changed_r;

endmodule

// File: rtl/soc_system_sw_poller.sv
// ---------------------------------------------------------------------------
// soc_system_sw_poller
// Avalon-MM master that periodically reads the switch PIO data register and
// presents a debounced switch vector to fabric logic.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   enable         polling enable
//   avm_address    word address to the PIO slave (always the data register)
//   avm_read       one-cycle read strobe per poll
//   avm_readdata   slave read data, bits [DATA_W-1:0] used
//   sw_stable      debounced switch value
//   sw_valid       high once the first debounced value is accepted
//   sw_changed     one-cycle pulse when sw_stable changes after sw_valid
// ---------------------------------------------------------------------------
module soc_system_sw_poller
    import soc_system_pio_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int POLL_DIV     = 50000,
    parameter int DEBOUNCE_N   = 4,
    parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic [1:0]        avm_address,
    output logic              avm_read,
    input  logic [31:0]       avm_readdata,
    output logic [DATA_W-1:0] sw_stable,
    output logic              sw_valid,
    output logic              sw_changed
);

    localparam int               DIV_W   = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(POLL_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    // WAIT covers READ_LATENCY-1 cycles; the counter counts 0..READ_LATENCY-2
    localparam int                WAIT_W    = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
    localparam int                WAIT_LAST_I = (READ_LATENCY >= 2) ? (READ_LATENCY - 2) : 0;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LAST_I);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    logic [DIV_W-1:0]  div_cnt_r;
    logic              tick_s;
    poll_state_e       state_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              avm_read_r;
    logic              sample_valid_s;
    logic              unused_readdata_s;

    // Poll divider: free-runs 0..POLL_DIV-1 while enabled, parked at 0 otherwise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_r <= '0;
        end else if (!enable) begin
            div_cnt_r <= '0;
        end else if (div_cnt_r == DIV_MAX) begin
            div_cnt_r <= '0;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
        end
    end

    // Poll request on the last divider count
    always_comb begin
        tick_s = 1'b0;
        if (enable && (div_cnt_r == DIV_MAX)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    // Avalon read FSM; avm_read is registered so it is high exactly in READ
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= '0;
            avm_read_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (tick_s) begin
                        state_r    <= ST_READ;
                        avm_read_r <= 1'b1;
                    end else begin
                        state_r    <= ST_IDLE;
                        avm_read_r <= 1'b0;
                    end
                end
                ST_READ: begin
                    avm_read_r <= 1'b0;
                    wait_cnt_r <= '0;
                    if (READ_LATENCY == 1) begin
                        state_r <= ST_CAPTURE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    avm_read_r <= 1'b0;
                    if (wait_cnt_r == WAIT_LAST) begin
                        state_r <= ST_CAPTURE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_ONE;
                    end
                end
                ST_CAPTURE: begin
                    avm_read_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    avm_read_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign sample_valid_s = (state_r == ST_CAPTURE);

    // Upper readdata bits carry nothing for this block
    assign unused_readdata_s = ^avm_readdata;

    soc_system_sw_debounce #(
        .DATA_W     (DATA_W),
        .DEBOUNCE_N (DEBOUNCE_N)
    ) u_debounce (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample       (avm_readdata[DATA_W-1:0]),
        .sample_valid (sample_valid_s),
        .stable       (sw_stable),
        .valid        (sw_valid),
        .changed      (sw_changed)
    );

    assign avm_address = PIO_DATA_OFFSET;
    assign avm_read    = avm_read_r;

endmodule

// File: tb/tb_soc_system_sw_poller.sv
// ---------------------------------------------------------------------------
// tb_soc_system_sw_poller
// Bench for soc_system_sw_poller with POLL_DIV=8, DEBOUNCE_N=3,
// READ_LATENCY=1, DATA_W=4. A registered slave returns {upper, in_port}.
// The reference model keeps the full sample history and accepts a value when
// its trailing run of identical samples reaches DEBOUNCE_N.
// ---------------------------------------------------------------------------
module tb_soc_system_sw_poller;

    localparam int DEB_N = 3;
    localparam int DIV   = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata = 32'd0;
    logic [3:0]  sw_stable;
    logic        sw_valid;
    logic        sw_changed;

    logic [3:0]  in_port = 4'd0;
    logic [27:0] upper   = 28'd0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int chg_seen = 0;
    int rd_seen  = 0;
    int addr_bad = 0;

    // reference model state
    logic [3:0] m_hist[$];
    logic [3:0] m_stable = 4'd0;
    logic       m_valid  = 1'b0;
    logic       m_chg    = 1'b0;
    int         m_chg_total = 0;

    soc_system_sw_poller #(
        .DATA_W       (4),
        .POLL_DIV     (DIV),
        .DEBOUNCE_N   (DEB_N),
        .READ_LATENCY (1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .avm_address  (avm_address),
        .avm_read     (avm_read),
        .avm_readdata (avm_readdata),
        .sw_stable    (sw_stable),
        .sw_valid     (sw_valid),
        .sw_changed   (sw_changed)
    );

    always #5 clk = ~clk;

    // cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // registered PIO slave, latency 1
    always @(posedge clk) begin
        if (avm_read && avm_address == 2'd0) avm_readdata <= {upper, in_port};
    end

    // event monitor
    always @(negedge clk) begin
        if (sw_changed === 1'b1) chg_seen <= chg_seen + 1;
        if (avm_read === 1'b1) rd_seen <= rd_seen + 1;
        if (avm_address !== 2'd0) addr_bad <= addr_bad + 1;
    end

    function automatic void model_reset();
        m_hist.delete();
        m_stable = 4'd0;
        m_valid  = 1'b0;
        m_chg    = 1'b0;
    endfunction

    function automatic void model_push(input logic [3:0] v);
        int run;
        m_hist.push_back(v);
        run = 0;
        for (int i = m_hist.size() - 1; i >= 0; i--) begin
            if (m_hist[i] != v) break;
            run++;
        end
        m_chg = 1'b0;
        if (run >= DEB_N && (v != m_stable || !m_valid)) begin
            m_chg = m_valid;
            if (m_valid) m_chg_total++;
            m_stable = v;
            m_valid  = 1'b1;
        end
    endfunction

    // Wait (bounded) for a read strobe; returns at the negedge of the READ cycle
    task automatic wait_read(output int rcyc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (avm_read !== 1'b1 && n < 40);
        total++;
        if (avm_read !== 1'b1) begin
            bad++;
            $display("FAIL read_timeout: no avm_read within %0d cycles (cycle %0d)", n, cyc);
        end
        rcyc = cyc;
    endtask

    // One poll: present v, wait for the read, return outputs at cycle R+2
    task automatic poll(input logic [3:0] v, output logic [5:0] obs, output int rcyc);
        in_port = v;
        wait_read(rcyc);
        model_push(v);
        @(negedge clk);
        @(negedge clk);
        obs = {sw_stable, sw_valid, sw_changed};
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        int r[3];
        reset_n = 1'b0;
        enable  = 1'b1;
        in_port = 4'hA;
        repeat (5) @(negedge clk);
        total++;
        if ({sw_stable, sw_valid, sw_changed, avm_read, avm_address} !== 9'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 0", {sw_stable, sw_valid, sw_changed, avm_read, avm_address});
        end
        model_reset();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            poll(4'hA, obs, r[i]);
            total++;
            if (obs !== {m_stable, m_valid, m_chg}) begin
                bad++;
                $display("FAIL startup_poll%0d: got %h want %h", i, obs, {m_stable, m_valid, m_chg});
            end
        end
        total++;
        if (obs !== {4'hA, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL startup_accept: got %h want %h", obs, {4'hA, 1'b1, 1'b0});
        end
        total++;
        if ((r[1] - r[0]) != DIV || (r[2] - r[1]) != DIV) begin
            bad++;
            $display("FAIL read_period: got %0d,%0d want %0d", r[1] - r[0], r[2] - r[1], DIV);
        end
        #1;
        total++;
        if (chg_seen != 0) begin
            bad++;
            $display("FAIL startup_no_change: got %0d pulses want 0", chg_seen);
        end
    endtask

    task automatic test_clean_change();
        logic [5:0] obs;
        int rc, c0;
        #1 c0 = chg_seen;
        for (int i = 0; i < 3; i++) begin
            poll(4'h5, obs, rc);
            total++;
            if (obs !== {m_stable, m_valid, m_chg}) begin
                bad++;
                $display("FAIL clean_poll%0d: got %h want %h", i, obs, {m_stable, m_valid, m_chg});
            end
        end
        total++;
        if (obs !== {4'h5, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL clean_update: got %h want %h", obs, {4'h5, 1'b1, 1'b1});
        end
        #1;
        total++;
        if (chg_seen - c0 != 1) begin
            bad++;
            $display("FAIL clean_pulse_count: got %0d want 1", chg_seen - c0);
        end
    endtask

    task automatic test_bounce();
        logic [5:0] obs;
        logic [3:0] v;
        int rc, c0, m0;
        for (int i = 0; i < 3; i++) poll(4'hA, obs, rc);
        #1 c0 = chg_seen;
        m0 = m_chg_total;
        for (int i = 0; i < 13; i++) begin
            v = (i >= 10) ? 4'h5 : ((i % 2 == 0) ? 4'h5 : 4'hA);
            poll(v, obs, rc);
            total++;
            if (obs !== {m_stable, m_valid, m_chg}) begin
                bad++;
                $display("FAIL bounce_poll%0d: got %h want %h", i, obs, {m_stable, m_valid, m_chg});
            end
            if (i == 11) begin
                total++;
                if (obs[5:2] !== 4'hA) begin
                    bad++;
                    $display("FAIL bounce_hold: got %h want a", obs[5:2]);
                end
            end
        end
        total++;
        if (obs[5:2] !== 4'h5) begin
            bad++;
            $display("FAIL bounce_final: got %h want 5", obs[5:2]);
        end
        #1;
        total++;
        if ((chg_seen - c0) != (m_chg_total - m0)) begin
            bad++;
            $display("FAIL bounce_pulses: got %0d want %0d", chg_seen - c0, m_chg_total - m0);
        end
    endtask

    task automatic test_random();
        logic [5:0] obs;
        logic [3:0] v;
        int rc, c0, m0;
        #1 c0 = chg_seen;
        m0 = m_chg_total;
        v = m_stable;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) v = 4'($urandom_range(0, 15));
            poll(v, obs, rc);
            total++;
            if (obs !== {m_stable, m_valid, m_chg}) begin
                bad++;
                $display("FAIL random_poll%0d: in %h got %h want %h", i, v, obs, {m_stable, m_valid, m_chg});
            end
        end
        #1;
        total++;
        if ((chg_seen - c0) != (m_chg_total - m0)) begin
            bad++;
            $display("FAIL random_pulses: got %0d want %0d", chg_seen - c0, m_chg_total - m0);
        end
    endtask

    task automatic test_enable_gating();
        logic [5:0] obs;
        int rc, rd0, ec;
        // bring in a new value partway so the gated read matters
        poll(4'h9, obs, rc);
        poll(4'h9, obs, rc);
        in_port = 4'h9;
        wait_read(rc);
        @(posedge clk);
        #1 enable = 1'b0;
        model_push(4'h9);
        @(negedge clk);
        @(negedge clk);
        obs = {sw_stable, sw_valid, sw_changed};
        total++;
        if (obs !== {m_stable, m_valid, m_chg}) begin
            bad++;
            $display("FAIL gated_capture: got %h want %h", obs, {m_stable, m_valid, m_chg});
        end
        #1 rd0 = rd_seen;
        repeat (30) @(negedge clk);
        #1;
        total++;
        if (rd_seen != rd0) begin
            bad++;
            $display("FAIL gated_no_read: got %0d reads want 0", rd_seen - rd0);
        end
        total++;
        if ({sw_stable, sw_valid} !== {m_stable, m_valid}) begin
            bad++;
            $display("FAIL gated_hold: got %h want %h", {sw_stable, sw_valid}, {m_stable, m_valid});
        end
        @(posedge clk);
        #1 enable = 1'b1;
        ec = cyc;
        in_port = 4'h9;
        wait_read(rc);
        total++;
        if (rc - ec != DIV) begin
            bad++;
            $display("FAIL reenable_latency: got %0d want %0d", rc - ec, DIV);
        end
        model_push(4'h9);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [5:0] obs;
        int rc, c0;
        in_port = ~m_stable;
        wait_read(rc);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        total++;
        if ({sw_stable, sw_valid, sw_changed, avm_read} !== 7'd0) begin
            bad++;
            $display("FAIL midreset_zero: got %b want 0", {sw_stable, sw_valid, sw_changed, avm_read});
        end
        model_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({sw_stable, sw_valid, sw_changed, avm_read} !== 7'd0) begin
            bad++;
            $display("FAIL midreset_hold: got %b want 0", {sw_stable, sw_valid, sw_changed, avm_read});
        end
        #1 c0 = chg_seen;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            poll(4'h6, obs, rc);
            total++;
            if (obs !== {m_stable, m_valid, m_chg}) begin
                bad++;
                $display("FAIL restart_poll%0d: got %h want %h", i, obs, {m_stable, m_valid, m_chg});
            end
        end
        #1;
        total++;
        if (chg_seen != c0 || obs !== {4'h6, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL restart_final: got %h pulses %0d want %h pulses 0", obs, chg_seen - c0, {4'h6, 1'b1, 1'b0});
        end
    endtask

    task automatic test_upper_bits();
        logic [5:0] obs;
        int rc;
        upper = 28'hFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            poll(4'h3, obs, rc);
            total++;
            if (obs !== {m_stable, m_valid, m_chg}) begin
                bad++;
                $display("FAIL upper_poll%0d: got %h want %h", i, obs, {m_stable, m_valid, m_chg});
            end
        end
        total++;
        if (obs[5:2] !== 4'h3) begin
            bad++;
            $display("FAIL upper_ignored: got %h want 3", obs[5:2]);
        end
        upper = 28'd0;
    endtask

    task automatic test_address();
        #1;
        total++;
        if (addr_bad != 0) begin
            bad++;
            $display("FAIL address_const: got %0d nonzero cycles want 0", addr_bad);
        end
    endtask

    initial begin
        test_reset();
        test_clean_change();
        test_bounce();
        test_random();
        test_enable_gating();
        test_reset_mid();
        test_upper_bits();
        test_address();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
